// File: rtl/glb_read_streamer_if.sv
// Purpose: groups the command, GLB read port and output stream signals of the read streamer.
// Latency: none; this is wiring only.
// Backpressure: carries cmd_valid/cmd_ready and out_valid/out_ready handshakes unchanged.
interface glb_read_streamer_if;
   // command channel
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_base;
   logic [15:0] cmd_len;
   logic [15:0] cmd_stride;
   // GLB read port
   logic [15:0] glb_addr;
   logic [3:0]  glb_w_en;
   logic [31:0] glb_rdata;
   // output word stream
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   // status
   logic        busy;
   logic        done;

   // streamer side
   modport slave (
      input  cmd_valid, cmd_base, cmd_len, cmd_stride,
      output cmd_ready,
      output glb_addr, glb_w_en,
      input  glb_rdata,
      output out_valid, out_data, out_last,
      input  out_ready,
      output busy, done
   );

   // command source / GLB / consumer side
   modport master (
      output cmd_valid, cmd_base, cmd_len, cmd_stride,
      input  cmd_ready,
      input  glb_addr, glb_w_en,
      output glb_rdata,
      input  out_valid, out_data, out_last,
      output out_ready,
      input  busy, done
   );
endinterface

// File: rtl/glb_read_streamer.sv
// Purpose: read DMA that walks base + i*stride over the GLB and streams the words in order.
// Latency: first out_valid READ_LAT+1 clocks after the accepting edge; then 1 word/clock.
// Backpressure: reads issue only while fifo_count + in-flight < FIFO_DEPTH, so out_ready low stalls issue, never drops.
module glb_read_streamer #(
   parameter int FIFO_DEPTH = 4,
   parameter int READ_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   glb_read_streamer_if.slave bus
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // command context
   logic        r_cmd_rdy;
   logic [15:0] r_addr;
   logic [15:0] r_stride;
   logic [15:0] r_len;
   logic [15:0] r_idx;
   logic [15:0] r_glb_addr;
   logic        r_done_z;

   // in-flight read tags, stage READ_LAT-1 lines up with glb_rdata
   logic [READ_LAT-1:0] r_tag_vld;
   logic [READ_LAT-1:0] r_tag_last;

   // output FIFO
   logic [31:0]           r_mem_dat [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_mem_last;
   logic [AW-1:0]         r_wptr;
   logic [AW-1:0]         r_rptr;
   logic [CW-1:0]         r_count;

   logic          w_accept;
   logic          w_issue;
   logic          w_issue_last;
   logic          w_cap;
   logic          w_pop;
   logic          w_head_last;
   logic          w_drain_done;
   logic [CW-1:0] w_inflight;
   logic [CW:0]   w_credit;

   assign w_accept     = bus.cmd_valid & r_cmd_rdy;
   assign w_issue_last = (r_idx == (r_len - 16'd1));
   assign w_cap        = r_tag_vld[READ_LAT-1];
   assign w_pop        = (r_count != '0) & bus.out_ready;
   assign w_head_last  = r_mem_last[r_rptr];

   // count reads issued but not yet captured
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < READ_LAT; i++) begin
         w_inflight = w_inflight + CW'(r_tag_vld[i]);
      end
      w_credit = {1'b0, r_count} + {1'b0, w_inflight};
   end

   // next state, issue decision and completion strobe
   always_comb begin
      w_state_nxt  = r_state;
      w_issue      = 1'b0;
      w_drain_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept && (bus.cmd_len != 16'd0)) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // uses the pre-pop count so a full FIFO never over-commits
            if (w_credit < (CW+1)'(FIFO_DEPTH)) begin
               w_issue = 1'b1;
               if (w_issue_last) begin
                  w_state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (w_pop && w_head_last) begin
               w_drain_done = 1'b1;
               w_state_nxt  = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // state register; cmd_ready is registered so it stays low through reset release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cmd_rdy <= 1'b0;
         r_done_z  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cmd_rdy <= (w_state_nxt == S_IDLE);
         r_done_z  <= w_accept && (bus.cmd_len == 16'd0);
      end
   end

   // latch the command and advance the address walk on each issue
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr     <= '0;
         r_stride   <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_glb_addr <= '0;
      end else if (w_accept) begin
         r_addr   <= bus.cmd_base & 16'hFFFC;
         r_stride <= bus.cmd_stride & 16'hFFFC;
         r_len    <= bus.cmd_len;
         r_idx    <= '0;
      end else if (w_issue) begin
         r_addr     <= r_addr + r_stride;
         r_idx      <= r_idx + 16'd1;
         r_glb_addr <= r_addr;
      end
   end

   // tag shift register tracking reads in the GLB pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tag_vld  <= '0;
         r_tag_last <= '0;
      end else begin
         for (int i = READ_LAT - 1; i > 0; i--) begin
            r_tag_vld[i]  <= r_tag_vld[i-1];
            r_tag_last[i] <= r_tag_last[i-1];
         end
         r_tag_vld[0]  <= w_issue;
         r_tag_last[0] <= w_issue & w_issue_last;
      end
   end

   // FIFO storage: capture tagged read data with its last flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem_dat[i] <= '0;
         end
         r_mem_last <= '0;
         r_wptr     <= '0;
      end else if (w_cap) begin
         r_mem_dat[r_wptr]  <= bus.glb_rdata;
         r_mem_last[r_wptr] <= r_tag_last[READ_LAT-1];
         r_wptr             <= r_wptr + AW'(1);
      end
   end

   // FIFO read pointer and occupancy; capture and pop in one cycle cancel out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_cap, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // the address is presented in the issue cycle and held afterwards
   assign bus.cmd_ready = r_cmd_rdy;
   assign bus.glb_addr  = w_issue ? r_addr : r_glb_addr;
   assign bus.glb_w_en  = 4'b0000;
   assign bus.out_valid = (r_count != '0);
   assign bus.out_data  = r_mem_dat[r_rptr];
   assign bus.out_last  = w_head_last;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = r_done_z | w_drain_done;

endmodule
